// File: rtl/pc_gen.sv
// Program-counter generation stage: holds the fetch PC, selects sequential/branch/jump next PC,
// and handles stall, halt and misaligned redirects. Define PC_GEN_TRAP_VEC_EN to trap instead of halt.
module pc_gen #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pc_valid,
  output logic        halted,
  output logic        misalign_fault,
  output logic [31:0] fault_pc,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic        fault_q, fault_d;

  logic        redirect;
  logic [31:0] target;
  logic        target_misaligned;

  // Jump outranks branch when both are presented in the same cycle.
  assign redirect          = jump_valid | branch_taken;
  assign target            = jump_valid ? jump_target : branch_target;
  assign target_misaligned = (target[1:0] != 2'b00);

`ifndef PC_GEN_TRAP_VEC_EN
  logic unused_trap_vector;
  assign unused_trap_vector = ^TRAP_VECTOR;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (halt_req) begin
          state_d = StHalt;
        end else if (!stall && redirect && target_misaligned) begin
`ifdef PC_GEN_TRAP_VEC_EN
          state_d = StRun;
`else
          state_d = StHalt;
`endif
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StHalt;
    endcase
  end

  // Output logic
  always_comb begin
    pc_valid = 1'b0;
    halted   = 1'b0;
    unique case (state_q)
      StRun:   pc_valid = 1'b1;
      StHalt:  halted   = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values
  always_comb begin
    pc_d       = pc_q;
    instret_d  = instret_q;
    fault_pc_d = fault_pc_q;
    fault_d    = 1'b0;
    if (state_q == StRun && !halt_req && !stall) begin
      if (redirect) begin
        if (!target_misaligned) begin
          pc_d      = target;
          instret_d = instret_q + 32'd1;
        end else begin
          fault_d    = 1'b1;
          fault_pc_d = pc_q;
`ifdef PC_GEN_TRAP_VEC_EN
          pc_d      = TRAP_VECTOR;
          instret_d = instret_q + 32'd1;
`endif
        end
      end else begin
        pc_d      = pc_plus4;
        instret_d = instret_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_VECTOR;
      instret_q  <= 32'd0;
      fault_pc_q <= 32'd0;
      fault_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instret_q  <= instret_d;
      fault_pc_q <= fault_pc_d;
      fault_q    <= fault_d;
    end
  end

  assign pc             = pc_q;
  assign pc_plus4       = pc_q + 32'd4;
  assign misalign_fault = fault_q;
  assign fault_pc       = fault_pc_q;
  assign instret        = instret_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed, table-driven bench for pc_gen; expectations follow the PC_GEN_TRAP_VEC_EN setting.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, halt_req, branch_taken, jump_valid;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc, pc_plus4, fault_pc, instret;
  logic        pc_valid, halted, misalign_fault;

  int n_checks = 0;
  int n_fail   = 0;

  pc_gen dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall         (stall),
    .halt_req      (halt_req),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_valid    (jump_valid),
    .jump_target   (jump_target),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .pc_valid      (pc_valid),
    .halted        (halted),
    .misalign_fault(misalign_fault),
    .fault_pc      (fault_pc),
    .instret       (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, hr, bt;
    logic [31:0] btgt;
    logic        jv;
    logic [31:0] jtgt;
    logic [31:0] pc;
    logic        vld, hlt, flt;
    logic [31:0] fpc, ir;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic hr, input logic bt, input logic [31:0] btgt,
                     input logic jv, input logic [31:0] jtgt, input logic [31:0] epc,
                     input logic vld, input logic hlt, input logic flt,
                     input logic [31:0] fpc, input logic [31:0] ir);
    vec_t v;
    v.st = st; v.hr = hr; v.bt = bt; v.btgt = btgt; v.jv = jv; v.jtgt = jtgt;
    v.pc = epc; v.vld = vld; v.hlt = hlt; v.flt = flt; v.fpc = fpc; v.ir = ir;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic st, input logic hr, input logic bt, input logic [31:0] btgt,
                       input logic jv, input logic [31:0] jtgt);
    stall = st; halt_req = hr; branch_taken = bt; branch_target = btgt;
    jump_valid = jv; jump_target = jtgt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    #3;
    chk("reset_pc", pc, 32'h0);
    chk("reset_valid", {31'd0, pc_valid}, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_fault", {31'd0, misalign_fault}, 32'd0);
    chk("reset_instret", instret, 32'd0);
    chk("reset_fault_pc", fault_pc, 32'd0);
    step();
    reset_n = 1'b1;
    chk("boot_valid", {31'd0, pc_valid}, 32'd0);

    //   st hr bt btgt        jv jtgt          pc            vld hlt flt fpc    ir
    add(0, 0, 0, 0,          0, 0,            32'h0,         1, 0, 0, 32'h0, 32'd0);
    add(0, 0, 0, 0,          0, 0,            32'h4,         1, 0, 0, 32'h0, 32'd1);
    add(0, 0, 0, 0,          0, 0,            32'h8,         1, 0, 0, 32'h0, 32'd2);
    add(0, 0, 0, 0,          0, 0,            32'hC,         1, 0, 0, 32'h0, 32'd3);
    add(0, 0, 0, 0,          0, 0,            32'h10,        1, 0, 0, 32'h0, 32'd4);
    add(0, 0, 1, 32'h40,     0, 0,            32'h40,        1, 0, 0, 32'h0, 32'd5);
    add(0, 0, 0, 0,          0, 0,            32'h44,        1, 0, 0, 32'h0, 32'd6);
    add(0, 0, 1, 32'h40,     1, 32'h80,       32'h80,        1, 0, 0, 32'h0, 32'd7);
    add(0, 0, 0, 0,          1, 32'h20,       32'h20,        1, 0, 0, 32'h0, 32'd8);
    add(1, 0, 1, 32'h100,    0, 0,            32'h20,        1, 0, 0, 32'h0, 32'd8);
    add(1, 0, 1, 32'h100,    0, 0,            32'h20,        1, 0, 0, 32'h0, 32'd8);
    add(1, 0, 1, 32'h100,    0, 0,            32'h20,        1, 0, 0, 32'h0, 32'd8);
    add(0, 0, 1, 32'h100,    0, 0,            32'h100,       1, 0, 0, 32'h0, 32'd9);
    add(0, 0, 0, 0,          1, 32'h30,       32'h30,        1, 0, 0, 32'h0, 32'd10);
`ifdef PC_GEN_TRAP_VEC_EN
    add(0, 0, 0, 0,          1, 32'h42,       32'h100,       1, 0, 1, 32'h30, 32'd11);
    add(0, 0, 0, 0,          0, 0,            32'h104,       1, 0, 0, 32'h30, 32'd12);
`else
    add(0, 0, 0, 0,          1, 32'h42,       32'h30,        0, 1, 1, 32'h30, 32'd10);
    add(0, 0, 1, 32'h40,     0, 0,            32'h30,        0, 1, 0, 32'h30, 32'd10);
`endif

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].hr, vecs[i].bt, vecs[i].btgt, vecs[i].jv, vecs[i].jtgt);
      step();
      chk($sformatf("v%0d_pc", i), pc, vecs[i].pc);
      chk($sformatf("v%0d_pc_plus4", i), pc_plus4, vecs[i].pc + 32'd4);
      chk($sformatf("v%0d_valid", i), {31'd0, pc_valid}, {31'd0, vecs[i].vld});
      chk($sformatf("v%0d_halted", i), {31'd0, halted}, {31'd0, vecs[i].hlt});
      chk($sformatf("v%0d_fault", i), {31'd0, misalign_fault}, {31'd0, vecs[i].flt});
      chk($sformatf("v%0d_fault_pc", i), fault_pc, vecs[i].fpc);
      chk($sformatf("v%0d_instret", i), instret, vecs[i].ir);
    end

    // Halt at 0x50, then redirects must not move the frozen PC.
    do_reset();
    step();
    drive(0, 0, 0, 0, 1, 32'h50);
    step();
    chk("halt_setup_pc", pc, 32'h50);
    drive(0, 1, 0, 0, 0, 0);
    step();
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_valid", {31'd0, pc_valid}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, i[0], 32'h200, i[1], 32'h300);
      step();
      chk($sformatf("halt_frozen_pc%0d", i), pc, 32'h50);
      chk($sformatf("halt_frozen_ir%0d", i), instret, 32'd1);
    end
    drive(0, 0, 1, 32'h200, 1, 32'h300);
    reset_n = 1'b0;
    #2;
    chk("async_reset_pc", pc, 32'h0);
    chk("async_reset_halted", {31'd0, halted}, 32'd0);
    chk("async_reset_instret", instret, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("reboot_pc", pc, 32'h0);
    chk("reboot_valid", {31'd0, pc_valid}, 32'd1);
    chk("reboot_ir", instret, 32'd0);

    // 32-bit PC wrap.
    drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc_top", pc, 32'hFFFF_FFFC);
    chk("wrap_plus4_top", pc_plus4, 32'h0);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_plus4", pc_plus4, 32'h4);
    chk("wrap_ir", instret, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Program-counter generation stage that sits directly upstream of the instruction fetch stage in the RV32I single-cycle core.
- Holds the architectural PC and drives it to fetch every cycle.
- Selects the next PC from sequential (+4), branch or jump sources, and supports pipeline stall and halt.
- Detects misaligned redirect targets and counts retired PC advances.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- TRAP_VECTOR, 32'h0000_0100, redirect target on misaligned fault; used only when the optional feature is compiled in.

Ports:
- clk  input  1  clock
- reset_n  input  1  reset
- stall  input  1  hold current PC this cycle
- halt_req  input  1  request to stop fetching (e.g. EBREAK decoded)
- branch_taken  input  1  conditional branch resolved taken
- branch_target  input  32  branch destination
- jump_valid  input  1  JAL/JALR redirect
- jump_target  input  32  jump destination; JALR bit 0 is cleared by the caller
- pc  output  32  current PC to fetch stage
- pc_plus4  output  32  pc + 4, for link-register writeback
- pc_valid  output  1  pc holds a fetchable address
- halted  output  1  block is in HALT state
- misalign_fault  output  1  one-cycle pulse when a redirect target has [1:0] != 0
- fault_pc  output  32  PC of the instruction that produced the last misaligned redirect
- instret  output  32  count of PC advances (wraps)

Behaviour:
- Reset is asynchronous and active-low on reset_n; clock is clk.
- Reset values:
  - pc = RESET_VECTOR
  - state = BOOT
  - pc_valid, halted, misalign_fault = 0
  - fault_pc, instret = 0
- pc_plus4 = pc + 32'd4, combinational, 32-bit wrap (32'hFFFF_FFFC -> 0).
- States:
  - BOOT: one cycle after reset release; pc = RESET_VECTOR, pc_valid = 0. Always -> RUN. Inputs are ignored.
  - RUN: pc_valid = 1. Next-PC priority (highest first):
    1. halt_req -> HALT; pc held; no instret increment.
    2. stall -> pc held; redirect inputs ignored (the producer holds them until stall drops); no increment.
    3. jump_valid -> target = jump_target.
    4. branch_taken -> target = branch_target.
    5. otherwise -> pc_plus4.
  - Redirect legality check, applied to levels 3 and 4 only:
    - target[1:0] == 0 -> pc <= target.
    - otherwise -> misaligned (see below).
  - Every accepted PC update increments instret by 1 (wraps at 2^32).
  - Misaligned redirect, base build:
    - pc not updated.
    - misalign_fault pulses for 1 cycle.
    - fault_pc <= current pc.
    - state -> HALT.
    - instret not incremented.
  - HALT: pc_valid = 0, halted = 1, pc frozen, all inputs ignored. Exit is by reset only.
- jump_valid and branch_taken asserted together: jump wins, branch is dropped silently.
- Reset asserted mid-operation, in any state: immediate return to reset values; no pending redirect survives.
- Fetch latency: a redirect accepted at edge N appears on pc after edge N, so the fetch stage uses it in cycle N+1.

Optional Feature:
- Macro: PC_GEN_TRAP_VEC_EN.
- Defined:
  - A misaligned redirect does not halt.
  - pc <= TRAP_VECTOR, misalign_fault pulses, fault_pc <= current pc, state stays RUN, instret increments.
  - halt_req behaviour is unchanged.
- Undefined: misaligned redirect -> HALT as described above; the TRAP_VECTOR parameter is unused.

Test Plan:
- Reset release, no other input -> cycle 0 pc = 0x0 with pc_valid = 0; cycle 1 pc_valid = 1; next edges pc = 0x4, 0x8, 0xC; instret = 1, 2, 3.
- At pc = 0x10: branch_taken = 1, branch_target = 0x40 for 1 cycle -> pc = 0x40 next cycle, then 0x44; with jump_valid = 1, jump_target = 0x80 asserted together -> pc = 0x80.
- stall held 3 cycles at pc = 0x20 with branch_taken = 1, target 0x100 -> pc stays 0x20 and instret is frozen; first unstalled edge -> pc = 0x100.
- jump_target = 0x42 at pc = 0x30:
  - base build -> misalign_fault pulse, fault_pc = 0x30, halted = 1, pc stays 0x30.
  - with PC_GEN_TRAP_VEC_EN -> pc = 0x100, halted = 0.
- halt_req at pc = 0x50 -> halted = 1, pc_valid = 0, pc frozen for 10 cycles despite redirects; reset_n pulse low mid-halt -> pc = RESET_VECTOR and BOOT again.
- Force pc to 0xFFFF_FFFC via jump, run 1 cycle -> pc = 0x0, pc_plus4 = 0x4; preload instret near 0xFFFF_FFFF and advance -> wraps to 0.
